// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b - bin, one bit per clock through a single full-subtractor cell.
// Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_sh, b_sh, bit_mask;
  logic             x_bit, y_bit, d_bit, bo_bit, last_bit;

  // Full-subtractor cell on the bit selected by cnt_q
  always_comb begin
    a_sh     = a_q >> cnt_q;
    b_sh     = b_q >> cnt_q;
    x_bit    = a_sh[0];
    y_bit    = b_sh[0];
    d_bit    = x_bit ^ y_bit ^ brw_q;
    bo_bit   = (~x_bit & y_bit) | (~x_bit & brw_q) | (y_bit & brw_q);
    bit_mask = WIDTH'(1) << cnt_q;
    last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = (diff_q & ~bit_mask) | (d_bit ? bit_mask : '0);
        brw_d  = bo_bit;
        if (last_bit) begin
          bout_d  = bo_bit;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow uses the MSB difference bit being produced on the final edge
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit)
      ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_bit ^ a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8); ovf expectations follow SERIAL_SUB_OVF_EN.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, bin;
  logic [7:0] a, b;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // Runs one subtraction; with ign=1 start is re-pulsed with junk operands mid-run.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tbin, input logic [7:0] ed, input logic eb,
                       input logic eo, input bit ign);
    int busy_cnt, done_cnt, done_idx;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55; bin = ~tbin;
    for (int i = 0; i < 15; i++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = i; end
      if (ign && (i == 2 || i == 7)) begin
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, busy_cnt, 9);
    chk({tag, ".done_pulses"}, done_cnt, 1);
    chk({tag, ".done_cycle"}, done_idx, 8);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, bout, eb);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 8'h00);
    chk("rst.bout", bout, 0);
    chk("rst.ovf",  ovf,  0);

    do_op("sub5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    do_op("sub3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_op("bin_only", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    do_op("ovf80_1",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OVF_ON, 1'b0);
    do_op("ignore",   8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1);

    // Abort mid-run: four bits processed, then reset
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h3C; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("abort.done_pulses", done_seen, 0);
    chk("abort.busy", busy, 0);
    chk("abort.diff", diff, 8'h00);
    chk("abort.bout", bout, 0);
    chk("abort.ovf",  ovf,  0);

    do_op("after_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
